// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 datapath: sequencer states, phase
// codes and S-memory geometry.
package arc4_pkg;

  localparam int unsigned S_DEPTH = 256;
  localparam int unsigned S_AW    = 8;

  typedef enum logic [3:0] {
    StIdle,
    StInitGo,
    StInitWait,
    StKsaGo,
    StKsaWait,
    StPrgaGo,
    StPrgaWait,
    StDone,
    StErr
  } sched_state_t;

  typedef enum logic [1:0] {
    PhIdle = 2'd0,
    PhInit = 2'd1,
    PhKsa  = 2'd2,
    PhPrga = 2'd3
  } phase_t;

  function automatic phase_t state_phase(sched_state_t s);
    case (s)
      StInitGo, StInitWait: return PhInit;
      StKsaGo, StKsaWait:   return PhKsa;
      StPrgaGo, StPrgaWait: return PhPrga;
      default:              return PhIdle;
    endcase
  endfunction

endpackage

// File: rtl/arc4_sched_if.sv
// Bundle of the sequencer's control handshakes, engine S-port requests and the
// muxed S-memory port. slave = the sequencer, master = wrapper plus engines.
interface arc4_sched_if #(
  parameter int unsigned KEY_W = 24
);
  import arc4_pkg::*;

  logic             en;
  logic             rdy;
  logic             err;
  logic             run_prga;
  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] key_q;
  phase_t           phase;

  logic init_en, init_rdy;
  logic ksa_en, ksa_rdy;
  logic prga_en, prga_rdy;

  logic [S_AW-1:0] init_addr, ksa_addr, prga_addr;
  logic [7:0]      init_wrdata, ksa_wrdata, prga_wrdata;
  logic            init_wren, ksa_wren, prga_wren;

  logic [S_AW-1:0] s_addr;
  logic [7:0]      s_wrdata;
  logic            s_wren;

  modport slave (
    input  en, run_prga, key, init_rdy, ksa_rdy, prga_rdy,
    input  init_addr, ksa_addr, prga_addr, init_wrdata, ksa_wrdata, prga_wrdata,
    input  init_wren, ksa_wren, prga_wren,
    output rdy, err, key_q, phase, init_en, ksa_en, prga_en, s_addr, s_wrdata, s_wren
  );

  modport master (
    output en, run_prga, key, init_rdy, ksa_rdy, prga_rdy,
    output init_addr, ksa_addr, prga_addr, init_wrdata, ksa_wrdata, prga_wrdata,
    output init_wren, ksa_wren, prga_wren,
    input  rdy, err, key_q, phase, init_en, ksa_en, prga_en, s_addr, s_wrdata, s_wren
  );

endinterface

// File: rtl/arc4_smem_mux.sv
// 3:1 S-memory port mux selected by the active phase; idle phase drives a
// quiet port so no engine write can leak outside its own phase.
module arc4_smem_mux
  import arc4_pkg::*;
(
  input  phase_t          i_phase,
  input  logic [S_AW-1:0] i_init_addr,
  input  logic [7:0]      i_init_wrdata,
  input  logic            i_init_wren,
  input  logic [S_AW-1:0] i_ksa_addr,
  input  logic [7:0]      i_ksa_wrdata,
  input  logic            i_ksa_wren,
  input  logic [S_AW-1:0] i_prga_addr,
  input  logic [7:0]      i_prga_wrdata,
  input  logic            i_prga_wren,
  output logic [S_AW-1:0] o_addr,
  output logic [7:0]      o_wrdata,
  output logic            o_wren
);

  always_comb begin
    o_addr   = '0;
    o_wrdata = '0;
    o_wren   = 1'b0;
    unique case (i_phase)
      PhInit: begin
        o_addr   = i_init_addr;
        o_wrdata = i_init_wrdata;
        o_wren   = i_init_wren;
      end
      PhKsa: begin
        o_addr   = i_ksa_addr;
        o_wrdata = i_ksa_wrdata;
        o_wren   = i_ksa_wren;
      end
      PhPrga: begin
        o_addr   = i_prga_addr;
        o_wrdata = i_prga_wrdata;
        o_wren   = i_prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 top-level sequencer: runs init, KSA and optional PRGA engines in order
// with a per-phase watchdog, and owns the single S-memory port.
module arc4_sched
  import arc4_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned KEY_W   = 24
) (
  input logic         clk,
  input logic         rst,
  arc4_sched_if.slave bus
);

  localparam int unsigned WdW = $clog2(TIMEOUT) + 1;

  sched_state_t     r_state, w_state_nxt;
  phase_t           r_phase;
  logic             r_err, r_run_prga, r_busy_seen;
  logic [KEY_W-1:0] r_key;
  logic [WdW-1:0]   r_wdog;
  logic             w_accept, w_expired, w_eng_rdy, w_in_go, w_in_wait;

  always_comb begin
    w_eng_rdy = 1'b0;
    w_in_go   = 1'b0;
    w_in_wait = 1'b0;
    unique case (r_state)
      StInitGo:   begin w_eng_rdy = bus.init_rdy; w_in_go   = 1'b1; end
      StInitWait: begin w_eng_rdy = bus.init_rdy; w_in_wait = 1'b1; end
      StKsaGo:    begin w_eng_rdy = bus.ksa_rdy;  w_in_go   = 1'b1; end
      StKsaWait:  begin w_eng_rdy = bus.ksa_rdy;  w_in_wait = 1'b1; end
      StPrgaGo:   begin w_eng_rdy = bus.prga_rdy; w_in_go   = 1'b1; end
      StPrgaWait: begin w_eng_rdy = bus.prga_rdy; w_in_wait = 1'b1; end
      default: ;
    endcase
  end

  assign w_accept  = (r_state inside {StIdle, StDone, StErr}) && bus.en;
  // >= rather than ==: a GO->WAIT step taken at TIMEOUT-1 lands one past it.
  assign w_expired = (r_wdog >= WdW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_phase <= PhIdle;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= state_phase(w_state_nxt);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle, StDone, StErr: if (bus.en) w_state_nxt = StInitGo;
      StInitGo, StKsaGo, StPrgaGo: begin
        if (w_eng_rdy)      w_state_nxt = sched_state_t'(r_state + 4'd1);
        else if (w_expired) w_state_nxt = StErr;
      end
      StInitWait: begin
        if (w_eng_rdy && r_busy_seen) w_state_nxt = StKsaGo;
        else if (w_expired)           w_state_nxt = StErr;
      end
      StKsaWait: begin
        if (w_eng_rdy && r_busy_seen) w_state_nxt = r_run_prga ? StPrgaGo : StDone;
        else if (w_expired)           w_state_nxt = StErr;
      end
      StPrgaWait: begin
        if (w_eng_rdy && r_busy_seen) w_state_nxt = StDone;
        else if (w_expired)           w_state_nxt = StErr;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key       <= '0;
      r_run_prga  <= 1'b0;
      r_err       <= 1'b0;
      r_wdog      <= '0;
      r_busy_seen <= 1'b0;
    end else begin
      if (w_accept) begin
        r_key      <= bus.key;
        r_run_prga <= bus.run_prga;
      end
      if (w_accept)                   r_err <= 1'b0;
      else if (w_state_nxt == StErr)  r_err <= 1'b1;
      if ((w_state_nxt != r_state) && (w_state_nxt inside {StInitGo, StKsaGo, StPrgaGo}))
        r_wdog <= '0;
      else if (w_in_go || w_in_wait)
        r_wdog <= r_wdog + 1'b1;
      if (w_in_go)                      r_busy_seen <= 1'b0;
      else if (w_in_wait && !w_eng_rdy) r_busy_seen <= 1'b1;
    end
  end

  always_comb begin
    bus.init_en = (r_state == StInitGo) && bus.init_rdy;
    bus.ksa_en  = (r_state == StKsaGo)  && bus.ksa_rdy;
    bus.prga_en = (r_state == StPrgaGo) && bus.prga_rdy;
    bus.rdy     = r_state inside {StIdle, StDone, StErr};
  end

  assign bus.err   = r_err;
  assign bus.phase = r_phase;
  assign bus.key_q = r_key;

  arc4_smem_mux u_smem_mux (
    .i_phase       (r_phase),
    .i_init_addr   (bus.init_addr),
    .i_init_wrdata (bus.init_wrdata),
    .i_init_wren   (bus.init_wren),
    .i_ksa_addr    (bus.ksa_addr),
    .i_ksa_wrdata  (bus.ksa_wrdata),
    .i_ksa_wren    (bus.ksa_wren),
    .i_prga_addr   (bus.prga_addr),
    .i_prga_wrdata (bus.prga_wrdata),
    .i_prga_wren   (bus.prga_wren),
    .o_addr        (bus.s_addr),
    .o_wrdata      (bus.s_wrdata),
    .o_wren        (bus.s_wren)
  );

endmodule

// File: tb/tb_arc4_sched.sv
// Directed bench for arc4_sched: two instances (long and 64-cycle watchdog)
// driven by stub engines that model the en/rdy handshake at the falling edge.
module tb_arc4_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arc4_sched_if #(.KEY_W(24)) ifc_a ();
  arc4_sched_if #(.KEY_W(24)) ifc_b ();

  arc4_sched #(.TIMEOUT(4096), .KEY_W(24)) u_dut_a (.clk(clk), .rst(rst), .bus(ifc_a));
  arc4_sched #(.TIMEOUT(64),   .KEY_W(24)) u_dut_b (.clk(clk), .rst(rst), .bus(ifc_b));

  // Stub engines: index 0..2 = a.init/ksa/prga, 3..5 = b.init/ksa/prga.
  logic st_en  [6];
  logic st_rdy [6];
  int   st_busy[6];
  bit   st_nodrop[6];
  bit   st_noraise[6];
  int   st_pulses[6];
  int   st_cnt [6];
  int   st_ph  [6];
  logic ksa_hold;

  assign st_en[0] = ifc_a.init_en;
  assign st_en[1] = ifc_a.ksa_en;
  assign st_en[2] = ifc_a.prga_en;
  assign st_en[3] = ifc_b.init_en;
  assign st_en[4] = ifc_b.ksa_en;
  assign st_en[5] = ifc_b.prga_en;

  assign ifc_a.init_rdy = st_rdy[0];
  assign ifc_a.ksa_rdy  = st_rdy[1] & ~ksa_hold;
  assign ifc_a.prga_rdy = st_rdy[2];
  assign ifc_b.init_rdy = st_rdy[3];
  assign ifc_b.ksa_rdy  = st_rdy[4];
  assign ifc_b.prga_rdy = st_rdy[5];

  // Each stub drives addr = its id, wrdata = 0x10 + id, wren = 1 permanently.
  assign ifc_a.init_addr = 8'd1;  assign ifc_a.init_wrdata = 8'h11;  assign ifc_a.init_wren = 1'b1;
  assign ifc_a.ksa_addr  = 8'd2;  assign ifc_a.ksa_wrdata  = 8'h12;  assign ifc_a.ksa_wren  = 1'b1;
  assign ifc_a.prga_addr = 8'd3;  assign ifc_a.prga_wrdata = 8'h13;  assign ifc_a.prga_wren = 1'b1;
  assign ifc_b.init_addr = 8'd1;  assign ifc_b.init_wrdata = 8'h11;  assign ifc_b.init_wren = 1'b1;
  assign ifc_b.ksa_addr  = 8'd2;  assign ifc_b.ksa_wrdata  = 8'h12;  assign ifc_b.ksa_wren  = 1'b1;
  assign ifc_b.prga_addr = 8'd3;  assign ifc_b.prga_wrdata = 8'h13;  assign ifc_b.prga_wren = 1'b1;

  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (rst) begin
        st_rdy[i] = 1'b1;
        st_ph[i]  = 0;
        st_cnt[i] = 0;
      end else begin
        case (st_ph[i])
          0: begin
            if (st_en[i]) begin
              st_pulses[i]++;
              st_ph[i] = 1;
            end else if (!st_rdy[i] && !st_noraise[i]) begin
              st_rdy[i] = 1'b1;
            end
          end
          1: begin
            if (!st_nodrop[i]) st_rdy[i] = 1'b0;
            st_cnt[i] = st_busy[i];
            st_ph[i]  = 2;
          end
          default: begin
            if (st_cnt[i] > 1) st_cnt[i]--;
            else begin
              if (!st_noraise[i]) st_rdy[i] = 1'b1;
              st_ph[i] = 0;
            end
          end
        endcase
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Follow dut a through phase from_ph until to_ph, checking the S-port owner.
  task automatic wait_a(input logic [1:0] from_ph, input logic [1:0] to_ph, input int bound,
                        input string tag);
    int n = 0;
    while (ifc_a.phase !== to_ph && n < bound) begin
      chk({tag, " phase"},  32'(ifc_a.phase), 32'(from_ph));
      chk({tag, " s_addr"}, 32'(ifc_a.s_addr), 32'(from_ph));
      chk({tag, " s_wrdata"}, 32'(ifc_a.s_wrdata), (from_ph == 2'd0) ? 32'h0 : 32'h10 + from_ph);
      chk({tag, " s_wren"}, 32'(ifc_a.s_wren), 32'(from_ph != 2'd0));
      step();
      n++;
    end
    chk({tag, " reached"}, 32'(n < bound), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0, b1, b2, b4, n;
    st_busy    = '{256, 768, 512, 10, 20, 20};
    st_nodrop  = '{default: 1'b0};
    st_noraise = '{default: 1'b0};
    ksa_hold = 1'b0;
    rst = 1'b1;
    ifc_a.en = 1'b0; ifc_a.run_prga = 1'b0; ifc_a.key = '0;
    ifc_b.en = 1'b0; ifc_b.run_prga = 1'b0; ifc_b.key = '0;
    step();
    step();

    chk("rst rdy",      32'(ifc_a.rdy), 32'd1);
    chk("rst err",      32'(ifc_a.err), 32'd0);
    chk("rst phase",    32'(ifc_a.phase), 32'd0);
    chk("rst init_en",  32'(ifc_a.init_en), 32'd0);
    chk("rst ksa_en",   32'(ifc_a.ksa_en), 32'd0);
    chk("rst prga_en",  32'(ifc_a.prga_en), 32'd0);
    chk("rst key_q",    32'(ifc_a.key_q), 32'd0);
    chk("rst s_wren",   32'(ifc_a.s_wren), 32'd0);
    chk("rst s_addr",   32'(ifc_a.s_addr), 32'd0);
    chk("rst s_wrdata", 32'(ifc_a.s_wrdata), 32'd0);
    rst = 1'b0;
    step();

    // Full run with PRGA, plus a stray en during KSA.
    b0 = st_pulses[0]; b1 = st_pulses[1]; b2 = st_pulses[2];
    ifc_a.key = 24'h000018; ifc_a.run_prga = 1'b1; ifc_a.en = 1'b1;
    step();
    ifc_a.en = 1'b0;
    chk("full rdy_fall", 32'(ifc_a.rdy), 32'd0);
    chk("full key_q",    32'(ifc_a.key_q), 32'h000018);
    chk("full init_en",  32'(ifc_a.init_en), 32'd1);
    wait_a(2'd1, 2'd2, 400, "full init");
    chk("full ksa_en",       32'(ifc_a.ksa_en), 32'd1);
    chk("full prga_pre_ksa", 32'(st_pulses[2] - b2), 32'd0);
    step();
    ifc_a.en = 1'b1; ifc_a.key = 24'hFFFFFF;
    step();
    ifc_a.en = 1'b0;
    chk("midksa rdy",     32'(ifc_a.rdy), 32'd0);
    chk("midksa phase",   32'(ifc_a.phase), 32'd2);
    chk("midksa key_q",   32'(ifc_a.key_q), 32'h000018);
    chk("midksa init_ct", 32'(st_pulses[0] - b0), 32'd1);
    wait_a(2'd2, 2'd3, 1000, "full ksa");
    chk("full prga_en", 32'(ifc_a.prga_en), 32'd1);
    wait_a(2'd3, 2'd0, 700, "full prga");
    chk("done rdy",     32'(ifc_a.rdy), 32'd1);
    chk("done err",     32'(ifc_a.err), 32'd0);
    chk("done s_wren",  32'(ifc_a.s_wren), 32'd0);
    chk("done s_addr",  32'(ifc_a.s_addr), 32'd0);
    chk("done key_q",   32'(ifc_a.key_q), 32'h000018);
    chk("done init_ct", 32'(st_pulses[0] - b0), 32'd1);
    chk("done ksa_ct",  32'(st_pulses[1] - b1), 32'd1);
    chk("done prga_ct", 32'(st_pulses[2] - b2), 32'd1);
    step();
    chk("post_done s_wren", 32'(ifc_a.s_wren), 32'd0);
    chk("post_done rdy",    32'(ifc_a.rdy), 32'd1);
    chk("post_done phase",  32'(ifc_a.phase), 32'd0);

    // KSA-only run: DONE the cycle after ksa_rdy rises.
    b2 = st_pulses[2];
    ifc_a.key = 24'hABCDEF; ifc_a.run_prga = 1'b0; ifc_a.en = 1'b1;
    step();
    ifc_a.en = 1'b0;
    wait_a(2'd1, 2'd2, 400, "noprga init");
    n = 0;
    do begin @(negedge clk); #1; n++; end while (ifc_a.ksa_rdy !== 1'b0 && n < 10);
    chk("noprga ksa_drop", 32'(ifc_a.ksa_rdy), 32'd0);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (ifc_a.ksa_rdy !== 1'b1 && n < 1000);
    chk("noprga ksa_rise",  32'(ifc_a.ksa_rdy), 32'd1);
    chk("noprga still_ksa", 32'(ifc_a.phase), 32'd2);
    step();
    chk("noprga done_phase", 32'(ifc_a.phase), 32'd0);
    chk("noprga done_rdy",   32'(ifc_a.rdy), 32'd1);
    chk("noprga prga_ct",    32'(st_pulses[2] - b2), 32'd0);
    chk("noprga key_q",      32'(ifc_a.key_q), 32'hABCDEF);

    // ksa_rdy held low at KSA_GO: ksa_en must wait for it.
    b1 = st_pulses[1];
    ksa_hold = 1'b1;
    ifc_a.en = 1'b1;
    step();
    ifc_a.en = 1'b0;
    wait_a(2'd1, 2'd2, 400, "hold init");
    for (int i = 0; i < 5; i++) begin
      chk("hold ksa_en", 32'(ifc_a.ksa_en), 32'd0);
      chk("hold phase",  32'(ifc_a.phase), 32'd2);
      step();
    end
    chk("hold ksa_ct", 32'(st_pulses[1] - b1), 32'd0);
    ksa_hold = 1'b0;
    #1;
    chk("release ksa_en", 32'(ifc_a.ksa_en), 32'd1);
    wait_a(2'd2, 2'd0, 1000, "hold ksa");
    chk("release ksa_ct", 32'(st_pulses[1] - b1), 32'd1);

    // Reset in the middle of KSA, then a clean run.
    ifc_a.key = 24'h123456; ifc_a.run_prga = 1'b1; ifc_a.en = 1'b1;
    step();
    ifc_a.en = 1'b0;
    wait_a(2'd1, 2'd2, 400, "mrst init");
    repeat (10) step();
    chk("mrst pre_wren", 32'(ifc_a.s_wren), 32'd1);
    chk("mrst pre_addr", 32'(ifc_a.s_addr), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst rdy",     32'(ifc_a.rdy), 32'd1);
    chk("mrst phase",   32'(ifc_a.phase), 32'd0);
    chk("mrst init_en", 32'(ifc_a.init_en), 32'd0);
    chk("mrst ksa_en",  32'(ifc_a.ksa_en), 32'd0);
    chk("mrst prga_en", 32'(ifc_a.prga_en), 32'd0);
    chk("mrst s_wren",  32'(ifc_a.s_wren), 32'd0);
    chk("mrst key_q",   32'(ifc_a.key_q), 32'd0);
    b0 = st_pulses[0]; b1 = st_pulses[1];
    ifc_a.key = 24'h000042; ifc_a.run_prga = 1'b0; ifc_a.en = 1'b1;
    step();
    ifc_a.en = 1'b0;
    wait_a(2'd1, 2'd2, 400, "rerun init");
    wait_a(2'd2, 2'd0, 1000, "rerun ksa");
    chk("rerun rdy",     32'(ifc_a.rdy), 32'd1);
    chk("rerun init_ct", 32'(st_pulses[0] - b0), 32'd1);
    chk("rerun ksa_ct",  32'(st_pulses[1] - b1), 32'd1);
    chk("rerun key_q",   32'(ifc_a.key_q), 32'h000042);

    // Watchdog (TIMEOUT=64): KSA engine drops rdy and never raises it.
    st_noraise[4] = 1'b1;
    b4 = st_pulses[4];
    ifc_b.run_prga = 1'b0; ifc_b.en = 1'b1;
    step();
    ifc_b.en = 1'b0;
    n = 0;
    while (ifc_b.phase !== 2'd2 && n < 100) begin step(); n++; end
    chk("to1 reach_ksa", 32'(n < 100), 32'd1);
    n = 0;
    while (ifc_b.phase === 2'd2 && n < 200) begin n++; step(); end
    chk("to1 ksa_cycles", 32'(n), 32'd64);
    chk("to1 err",        32'(ifc_b.err), 32'd1);
    chk("to1 rdy",        32'(ifc_b.rdy), 32'd1);
    chk("to1 phase",      32'(ifc_b.phase), 32'd0);
    chk("to1 s_wren",     32'(ifc_b.s_wren), 32'd0);
    chk("to1 ksa_ct",     32'(st_pulses[4] - b4), 32'd1);
    step();
    chk("to1 err_sticky", 32'(ifc_b.err), 32'd1);
    chk("to1 ksa_en_off", 32'(ifc_b.ksa_en), 32'd0);

    // New en clears err and restarts at INIT; KSA engine now never drops rdy.
    st_noraise[4] = 1'b0;
    st_nodrop[4]  = 1'b1;
    ifc_b.en = 1'b1;
    #1;
    chk("to2 err_before", 32'(ifc_b.err), 32'd1);
    step();
    ifc_b.en = 1'b0;
    chk("to2 err_clear", 32'(ifc_b.err), 32'd0);
    chk("to2 phase",     32'(ifc_b.phase), 32'd1);
    chk("to2 rdy",       32'(ifc_b.rdy), 32'd0);
    chk("to2 init_en",   32'(ifc_b.init_en), 32'd1);
    n = 0;
    while (ifc_b.phase !== 2'd2 && n < 100) begin step(); n++; end
    chk("to2 reach_ksa", 32'(n < 100), 32'd1);
    n = 0;
    while (ifc_b.phase === 2'd2 && n < 200) begin n++; step(); end
    chk("to2 ksa_cycles", 32'(n), 32'd64);
    chk("to2 err",        32'(ifc_b.err), 32'd1);
    chk("to2 rdy",        32'(ifc_b.rdy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
